// File: rtl/scanout_pkg.sv
`default_nettype none
// ============================================================================
// Package     : scanout_pkg
// Description : Shared constants, types and helpers for the display scan-out
//               stage: 640x480@60 raster timing, RGB444 pixel width and the
//               tile-ordered framebuffer address format.
// Revision    : 1.0 - initial release
// ============================================================================
package scanout_pkg;

   // Horizontal timing in pixels
   localparam int c_H_VIS        = 640;
   localparam int c_H_FP         = 16;
   localparam int c_H_SYNC       = 96;
   localparam int c_H_BP         = 48;
   localparam int c_H_TOTAL      = c_H_VIS + c_H_FP + c_H_SYNC + c_H_BP;   // 800
   localparam int c_HSYNC_START  = c_H_VIS + c_H_FP;                      // 656
   localparam int c_HSYNC_END    = c_HSYNC_START + c_H_SYNC - 1;          // 751

   // Vertical timing in lines
   localparam int c_V_VIS        = 480;
   localparam int c_V_FP         = 10;
   localparam int c_V_SYNC       = 2;
   localparam int c_V_BP         = 33;
   localparam int c_V_TOTAL      = c_V_VIS + c_V_FP + c_V_SYNC + c_V_BP;   // 525
   localparam int c_VSYNC_START  = c_V_VIS + c_V_FP;                      // 490
   localparam int c_VSYNC_END    = c_VSYNC_START + c_V_SYNC - 1;          // 491

   localparam int c_DATA_W       = 12;
   localparam int c_FB_ADDR_W    = 20;
   localparam int c_CNT_W        = 10;
   localparam int c_FRAME_CNT_W  = 8;

   // Raster decode for one counter position; travels down the delay line
   // so that sync and data-enable stay aligned with pixel data.
   typedef struct packed {
      logic vis;
      logic hsync;    // active-high here, inverted at the pin
      logic vsync;    // active-high here, inverted at the pin
   } video_ctl_t;

   // Tile-ordered address: 16x16 tiles, tiles row-major, pixels row-major
   // inside a tile. Pure bit concatenation, so no multiplier is needed.
   function automatic logic [c_FB_ADDR_W-1:0] tile_addr(
      input logic [c_CNT_W-1:0] x,
      input logic [c_CNT_W-1:0] y
   );
      return {y[9:4], x[9:4], y[3:0], x[3:0]};
   endfunction

endpackage
`default_nettype wire

// File: rtl/scanout_timing.sv
`default_nettype none
// ============================================================================
// Module      : scanout_timing
// Description : Raster counters and their decodes. h/v counters, visible and
//               sync windows (combinational, for the video delay line),
//               registered frame-start pulse, vblank flag and frame counter.
// Ports       : clk, reset_n          - pixel clock, async active-low reset
//               o_h_cnt, o_v_cnt      - current counter position
//               o_ctl                 - visible/hsync/vsync decode of counters
//               o_frame_wrap          - last cycle of the frame (799,524)
//               o_frame_start         - registered pulse for counter (0,0)
//               o_vblank              - registered v_cnt >= V_VIS
//               o_frame_cnt           - frames completed, wraps 255->0
// Revision    : 1.0 - initial release
// ============================================================================
module scanout_timing
   import scanout_pkg::*;
#(
   parameter int H_VIS  = c_H_VIS,
   parameter int H_FP   = c_H_FP,
   parameter int H_SYNC = c_H_SYNC,
   parameter int H_BP   = c_H_BP,
   parameter int V_VIS  = c_V_VIS,
   parameter int V_FP   = c_V_FP,
   parameter int V_SYNC = c_V_SYNC,
   parameter int V_BP   = c_V_BP
) (
   input  logic                     clk,
   input  logic                     reset_n,
   output logic [c_CNT_W-1:0]       o_h_cnt,
   output logic [c_CNT_W-1:0]       o_v_cnt,
   output video_ctl_t               o_ctl,
   output logic                     o_frame_wrap,
   output logic                     o_frame_start,
   output logic                     o_vblank,
   output logic [c_FRAME_CNT_W-1:0] o_frame_cnt
);

   localparam logic [c_CNT_W-1:0] c_H_LAST    = c_CNT_W'(H_VIS + H_FP + H_SYNC + H_BP - 1);
   localparam logic [c_CNT_W-1:0] c_V_LAST    = c_CNT_W'(V_VIS + V_FP + V_SYNC + V_BP - 1);
   localparam logic [c_CNT_W-1:0] c_H_VIS_CNT = c_CNT_W'(H_VIS);
   localparam logic [c_CNT_W-1:0] c_V_VIS_CNT = c_CNT_W'(V_VIS);
   localparam logic [c_CNT_W-1:0] c_HS_FIRST  = c_CNT_W'(H_VIS + H_FP);
   localparam logic [c_CNT_W-1:0] c_HS_LAST   = c_CNT_W'(H_VIS + H_FP + H_SYNC - 1);
   localparam logic [c_CNT_W-1:0] c_VS_FIRST  = c_CNT_W'(V_VIS + V_FP);
   localparam logic [c_CNT_W-1:0] c_VS_LAST   = c_CNT_W'(V_VIS + V_FP + V_SYNC - 1);

   logic [c_CNT_W-1:0]       r_h_cnt;
   logic [c_CNT_W-1:0]       r_v_cnt;
   logic                     r_frame_start;
   logic                     r_vblank;
   logic [c_FRAME_CNT_W-1:0] r_frame_cnt;

   logic w_h_last;
   logic w_v_last;
   logic w_frame_wrap;

   assign w_h_last     = (r_h_cnt == c_H_LAST);
   assign w_v_last     = (r_v_cnt == c_V_LAST);
   assign w_frame_wrap = w_h_last && w_v_last;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_h_cnt <= '0;
         r_v_cnt <= '0;
      end else if (w_h_last) begin
         r_h_cnt <= '0;
         r_v_cnt <= w_v_last ? '0 : r_v_cnt + 1'b1;
      end else begin
         r_h_cnt <= r_h_cnt + 1'b1;
      end
   end

   // Status is registered one cycle after the counters and is deliberately
   // not aligned to the delayed video outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_frame_start <= 1'b0;
         r_vblank      <= 1'b0;
         r_frame_cnt   <= '0;
      end else begin
         r_frame_start <= (r_h_cnt == '0) && (r_v_cnt == '0);
         r_vblank      <= (r_v_cnt >= c_V_VIS_CNT);
         if (w_frame_wrap) begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
         end
      end
   end

   assign o_h_cnt       = r_h_cnt;
   assign o_v_cnt       = r_v_cnt;
   assign o_ctl.vis     = (r_h_cnt < c_H_VIS_CNT) && (r_v_cnt < c_V_VIS_CNT);
   assign o_ctl.hsync   = (r_h_cnt >= c_HS_FIRST) && (r_h_cnt <= c_HS_LAST);
   assign o_ctl.vsync   = (r_v_cnt >= c_VS_FIRST) && (r_v_cnt <= c_VS_LAST);
   assign o_frame_wrap  = w_frame_wrap;
   assign o_frame_start = r_frame_start;
   assign o_vblank      = r_vblank;
   assign o_frame_cnt   = r_frame_cnt;

endmodule
`default_nettype wire

// File: rtl/scanout_controller.sv
`default_nettype none
// ============================================================================
// Module      : scanout_controller
// Description : Display scan-out stage. Generates raster timing, reads pixels
//               from the tile-ordered framebuffer and drives registered RGB
//               and sync to the video DAC, with per-frame output enable.
// Ports       : clk, reset_n          - pixel clock, async active-low reset
//               i_output_ena          - output enable, taken at frame boundary
//               o_fb_rd_en, o_fb_addr - framebuffer read strobe / address
//               i_fb_data             - read data, one cycle after o_fb_rd_en
//               o_rgb, o_de           - pixel and data-enable to DAC
//               o_hsync, o_vsync      - active-low syncs to DAC
//               o_frame_start, o_vblank, o_frame_cnt - status to render side
// Revision    : 1.0 - initial release
// ============================================================================
module scanout_controller
   import scanout_pkg::*;
#(
   parameter int H_VIS  = c_H_VIS,
   parameter int H_FP   = c_H_FP,
   parameter int H_SYNC = c_H_SYNC,
   parameter int H_BP   = c_H_BP,
   parameter int V_VIS  = c_V_VIS,
   parameter int V_FP   = c_V_FP,
   parameter int V_SYNC = c_V_SYNC,
   parameter int V_BP   = c_V_BP,
   parameter int DATA_W = c_DATA_W
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     i_output_ena,
   output logic                     o_fb_rd_en,
   output logic [c_FB_ADDR_W-1:0]   o_fb_addr,
   input  logic [DATA_W-1:0]        i_fb_data,
   output logic [DATA_W-1:0]        o_rgb,
   output logic                     o_de,
   output logic                     o_hsync,
   output logic                     o_vsync,
   output logic                     o_frame_start,
   output logic                     o_vblank,
   output logic [c_FRAME_CNT_W-1:0] o_frame_cnt
);

   logic [c_CNT_W-1:0] w_h_cnt;
   logic [c_CNT_W-1:0] w_v_cnt;
   video_ctl_t         w_ctl;
   logic               w_frame_wrap;

   logic                   r_frame_ena;
   logic                   r_fb_rd_en;
   logic [c_FB_ADDR_W-1:0] r_fb_addr;
   video_ctl_t             r_ctl_d1;
   video_ctl_t             r_ctl_d2;
   logic [DATA_W-1:0]      r_rgb;
   logic                   r_de;
   logic                   r_hsync;
   logic                   r_vsync;

   scanout_timing #(
      .H_VIS  (H_VIS),
      .H_FP   (H_FP),
      .H_SYNC (H_SYNC),
      .H_BP   (H_BP),
      .V_VIS  (V_VIS),
      .V_FP   (V_FP),
      .V_SYNC (V_SYNC),
      .V_BP   (V_BP)
   ) u_timing (
      .clk           (clk),
      .reset_n       (reset_n),
      .o_h_cnt       (w_h_cnt),
      .o_v_cnt       (w_v_cnt),
      .o_ctl         (w_ctl),
      .o_frame_wrap  (w_frame_wrap),
      .o_frame_start (o_frame_start),
      .o_vblank      (o_vblank),
      .o_frame_cnt   (o_frame_cnt)
   );

   // The enable only changes on the last cycle of a frame, so a frame is
   // never partially blanked by a mid-frame register write.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_frame_ena <= 1'b1;
      end else if (w_frame_wrap) begin
         r_frame_ena <= i_output_ena;
      end
   end

   // Stage 1: framebuffer request; stages 2-3: control delay matching the
   // one-cycle memory read so sync/de leave together with the pixel.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_fb_rd_en <= 1'b0;
         r_fb_addr  <= '0;
         r_ctl_d1   <= '0;
         r_ctl_d2   <= '0;
         r_rgb      <= '0;
         r_de       <= 1'b0;
         r_hsync    <= 1'b1;
         r_vsync    <= 1'b1;
      end else begin
         r_fb_rd_en <= w_ctl.vis && r_frame_ena;
         r_fb_addr  <= tile_addr(w_h_cnt, w_v_cnt);
         r_ctl_d1   <= w_ctl;
         r_ctl_d2   <= r_ctl_d1;
         r_rgb      <= (r_ctl_d2.vis && r_frame_ena) ? i_fb_data : '0;
         r_de       <= r_ctl_d2.vis;
         r_hsync    <= ~r_ctl_d2.hsync;
         r_vsync    <= ~r_ctl_d2.vsync;
      end
   end

   assign o_fb_rd_en = r_fb_rd_en;
   assign o_fb_addr  = r_fb_addr;
   assign o_rgb      = r_rgb;
   assign o_de       = r_de;
   assign o_hsync    = r_hsync;
   assign o_vsync    = r_vsync;

endmodule
`default_nettype wire

// File: tb/tb_scanout_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_scanout_controller
// Description : Self-checking bench. Three instances: default 640x480 timing
//               (line timing, address map, reset), a reduced raster with a
//               scoreboard (pixels, sync, status, enable gating) and a tiny
//               raster for the 8-bit frame counter wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scanout_controller;

   // Reduced raster for the scoreboard instance
   localparam int SH_VIS = 24, SH_TOT = 40, SHS0 = 28, SHS1 = 33;
   localparam int SV_VIS = 36, SV_TOT = 42, SVS0 = 38, SVS1 = 39;

   logic clk;
   logic reset_n;
   logic ena_d, ena_s, ena_t;
   logic [11:0] fb_d, fb_s, fb_t;

   logic        d_rd, d_de, d_hs, d_vs, d_fs, d_vb;
   logic [19:0] d_addr;
   logic [11:0] d_rgb;
   logic [7:0]  d_fcnt;
   logic        s_rd, s_de, s_hs, s_vs, s_fs, s_vb;
   logic [19:0] s_addr;
   logic [11:0] s_rgb;
   logic [7:0]  s_fcnt;
   logic        t_rd, t_de, t_hs, t_vs, t_fs, t_vb;
   logic [19:0] t_addr;
   logic [11:0] t_rgb;
   logic [7:0]  t_fcnt;

   int n_vec = 0;
   int n_err = 0;

   scanout_controller u_dut_d (
      .clk(clk), .reset_n(reset_n), .i_output_ena(ena_d),
      .o_fb_rd_en(d_rd), .o_fb_addr(d_addr), .i_fb_data(fb_d),
      .o_rgb(d_rgb), .o_de(d_de), .o_hsync(d_hs), .o_vsync(d_vs),
      .o_frame_start(d_fs), .o_vblank(d_vb), .o_frame_cnt(d_fcnt));

   scanout_controller #(
      .H_VIS(24), .H_FP(4), .H_SYNC(6), .H_BP(6),
      .V_VIS(36), .V_FP(2), .V_SYNC(2), .V_BP(2)
   ) u_dut_s (
      .clk(clk), .reset_n(reset_n), .i_output_ena(ena_s),
      .o_fb_rd_en(s_rd), .o_fb_addr(s_addr), .i_fb_data(fb_s),
      .o_rgb(s_rgb), .o_de(s_de), .o_hsync(s_hs), .o_vsync(s_vs),
      .o_frame_start(s_fs), .o_vblank(s_vb), .o_frame_cnt(s_fcnt));

   scanout_controller #(
      .H_VIS(2), .H_FP(1), .H_SYNC(1), .H_BP(1),
      .V_VIS(2), .V_FP(1), .V_SYNC(1), .V_BP(1)
   ) u_dut_t (
      .clk(clk), .reset_n(reset_n), .i_output_ena(ena_t),
      .o_fb_rd_en(t_rd), .o_fb_addr(t_addr), .i_fb_data(fb_t),
      .o_rgb(t_rgb), .o_de(t_de), .o_hsync(t_hs), .o_vsync(t_vs),
      .o_frame_start(t_fs), .o_vblank(t_vb), .o_frame_cnt(t_fcnt));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Framebuffer contents; one location carries a recognisable marker
   function automatic logic [11:0] mem(input logic [19:0] a);
      if (a == 20'h08111) return 12'hABC;
      return a[11:0] ^ {a[19:12], 4'h5};
   endfunction

   // Tile address written arithmetically, independent of bit slicing
   function automatic logic [19:0] saddr(input int x, input int y);
      return 20'((y / 16) * 16384 + (x / 16) * 256 + (y % 16) * 16 + (x % 16));
   endfunction

   // Memory model: data for a request seen in cycle t+1 is held during t+2
   logic [11:0] pend_d, pend_s;
   initial begin
      fb_d = '0; fb_s = '0; fb_t = '0;
      forever begin
         @(negedge clk);
         pend_d = d_rd ? mem(d_addr) : 12'hFFF;
         pend_s = s_rd ? mem(s_addr) : 12'hFFF;
         @(posedge clk);
         #1;
         fb_d = pend_d;
         fb_s = pend_s;
      end
   end

   // ---------------- Scoreboard model for the reduced raster ---------------
   int          sh = 0, sv = 0;
   logic        s_fena = 1'b1;
   logic [2:0]  e1 = 3'b011, e2 = 3'b011, e3 = 3'b011;   // {de, hsync_n, vsync_n}
   logic        st_fs = 1'b0, st_vb = 1'b0;
   logic [19:0] q_rd[$];
   logic [11:0] q_pix[$];

   initial begin
      forever begin
         @(posedge clk or negedge reset_n);
         if (!reset_n) begin
            sh = 0; sv = 0; s_fena = 1'b1;
            e1 = 3'b011; e2 = 3'b011; e3 = 3'b011;
            st_fs = 1'b0; st_vb = 1'b0;
            q_rd.delete(); q_pix.delete();
         end else begin
            logic vis;
            vis = (sh < SH_VIS) && (sv < SV_VIS);
            e3 = e2; e2 = e1;
            e1 = {vis, !(sh >= SHS0 && sh <= SHS1), !(sv >= SVS0 && sv <= SVS1)};
            st_fs = (sh == 0) && (sv == 0);
            st_vb = (sv >= SV_VIS);
            if (vis) begin
               if (s_fena) begin
                  q_rd.push_back(saddr(sh, sv));
                  q_pix.push_back(mem(saddr(sh, sv)));
               end else begin
                  q_pix.push_back(12'h000);
               end
            end
            if (sh == SH_TOT - 1 && sv == SV_TOT - 1) s_fena = ena_s;
            if (sh == SH_TOT - 1) begin
               sh = 0;
               sv = (sv == SV_TOT - 1) ? 0 : sv + 1;
            end else begin
               sh = sh + 1;
            end
         end
      end
   end

   // Monitor: pops expected reads/pixels whenever the DUT presents them
   initial begin
      forever begin
         @(negedge clk);
         if (reset_n) begin
            chk("s_de", s_de, e3[2]);
            chk("s_hsync", s_hs, e3[1]);
            chk("s_vsync", s_vs, e3[0]);
            chk("s_frame_start", s_fs, st_fs);
            chk("s_vblank", s_vb, st_vb);
            if (s_rd) begin
               chk("s_rd_expected", q_rd.size() != 0, 1);
               if (q_rd.size() != 0) chk("s_addr", s_addr, q_rd.pop_front());
            end
            if (s_de) begin
               chk("s_pix_expected", q_pix.size() != 0, 1);
               if (q_pix.size() != 0) chk("s_rgb", s_rgb, q_pix.pop_front());
            end else begin
               chk("s_rgb_blank", s_rgb, 12'h000);
            end
         end
      end
   end

   // ---------------- Frame counter wrap on the tiny raster -----------------
   int t_pulses = 0;
   initial begin
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            t_pulses = 0;
         end else if (t_fs) begin
            t_pulses++;
            chk("t_frame_cnt", t_fcnt, (t_pulses - 1) % 256);
         end
      end
   end

   // ---------------- Line timing on the default raster ---------------------
   logic d_arm = 1'b0;
   int   dcyc = 0, last_hs_fall = -1, de_rise = -1, de_fall = -1, n_hs_falls = 0;
   logic prev_hs = 1'b1, prev_de = 1'b0;
   initial begin
      forever begin
         @(negedge clk);
         if (d_arm) begin
            if (prev_hs && !d_hs) begin
               if (last_hs_fall >= 0) chk("d_hsync_period", dcyc - last_hs_fall, 800);
               if (de_fall >= 0) begin
                  chk("d_de_to_hsync", dcyc - de_fall, 16);
                  de_fall = -1;
               end
               last_hs_fall = dcyc;
               n_hs_falls++;
            end
            if (!prev_hs && d_hs && last_hs_fall >= 0) chk("d_hsync_width", dcyc - last_hs_fall, 96);
            if (!prev_de && d_de) de_rise = dcyc;
            if (prev_de && !d_de && de_rise >= 0) begin
               chk("d_de_width", dcyc - de_rise, 640);
               de_fall = dcyc;
            end
         end
         prev_hs = d_hs;
         prev_de = d_de;
         dcyc++;
      end
   end

   // ---------------- Enable gating stimulus on the reduced raster ----------
   logic rel2 = 1'b0;
   initial begin
      ena_s = 1'b1;
      wait (rel2);
      repeat (2080) @(negedge clk);   // frame 1, line 10
      ena_s = 1'b0;
      repeat (2080) @(negedge clk);   // frame 2, line 20
      ena_s = 1'b1;
   end

   // ---------------- Main sequence -----------------------------------------
   initial begin
      reset_n = 1'b0;
      ena_d = 1'b1;
      ena_t = 1'b1;
      repeat (5) @(negedge clk);
      reset_n = 1'b1;

      // Let every instance reach a busy mid-line state, then reset async
      repeat (300) @(posedge clk);
      #3 reset_n = 1'b0;
      #1;
      chk("rst_d_rgb", d_rgb, 12'h000);
      chk("rst_d_de", d_de, 1'b0);
      chk("rst_d_hsync", d_hs, 1'b1);
      chk("rst_d_vsync", d_vs, 1'b1);
      chk("rst_d_rd_en", d_rd, 1'b0);
      chk("rst_d_addr", d_addr, 20'h0);
      chk("rst_d_frame_start", d_fs, 1'b0);
      chk("rst_d_vblank", d_vb, 1'b0);
      chk("rst_d_frame_cnt", d_fcnt, 8'h0);
      chk("rst_s_rgb", s_rgb, 12'h000);
      chk("rst_s_de", s_de, 1'b0);
      chk("rst_s_rd_en", s_rd, 1'b0);
      chk("rst_t_frame_cnt", t_fcnt, 8'h0);

      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      rel2 = 1'b1;
      d_arm = 1'b1;

      // Cycle index k at each negedge equals the counter value h + 800*v
      @(negedge clk);                                   // k = 1
      chk("d_frame_start_pulse", d_fs, 1'b1);
      @(negedge clk);                                   // k = 2
      chk("d_frame_start_end", d_fs, 1'b0);

      repeat (26417 - 2) @(negedge clk);                // k = 26417
      chk("d_rd_x16_y33", d_rd, 1'b1);
      chk("d_addr_x16_y33", d_addr, 20'h08110);
      @(negedge clk);                                   // k = 26418
      chk("d_rd_x17_y33", d_rd, 1'b1);
      chk("d_addr_x17_y33", d_addr, 20'h08111);
      @(negedge clk);                                   // k = 26419
      chk("d_addr_x18_y33", d_addr, 20'h08112);
      @(negedge clk);                                   // k = 26420
      chk("d_rgb_x17_y33", d_rgb, 12'hABC);
      chk("d_de_x17_y33", d_de, 1'b1);
      @(negedge clk);                                   // k = 26421
      chk("d_rgb_x18_y33", d_rgb, 12'h197);

      repeat (4) @(negedge clk);
      chk("d_lines_seen", n_hs_falls >= 30, 1);
      chk("t_frames_seen", t_pulses >= 257, 1);
      chk("s_rd_queue_drained", q_rd.size() <= 1, 1);
      chk("s_pix_queue_drained", q_pix.size() <= 3, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
